frame_bank_scheduler: RTL and testbench
=======================================

// Module: frame_bank_scheduler
// PURPOSE
//  Ping-pong controller for the two-bank frame buffer between camera capture and display.
//  Generates write addresses and bank selects for incoming camera pixels.
//  Holds the display on the other bank and swaps banks only at display start-of-frame, so output never tears.
//  Counts frames dropped when the display has not consumed a completed frame.
// PARAMETERS
//  WIDTH   320  pixels per row
//  HEIGHT  240  rows per frame (must be even)
//  ADDR_W  17   buffer address width; WIDTH*HEIGHT <= 2**ADDR_W
//  PIX_W   24   pixel width (RGB888)
// PORTS
//  clk             in   1       system clock
//  reset           in   1       synchronous, active-high reset
//  cam_sof         in   1       1-cycle pulse before the first pixel of a frame (or field)
//  cam_valid       in   1       cam_pixel valid this cycle
//  cam_pixel       in   PIX_W   camera pixel, raster order
//  disp_sof        in   1       1-cycle pulse at start of display frame (vsync)
//  disp_addr       in   ADDR_W  display read address within a frame
//  wr_en           out  1       buffer write strobe
//  wr_bank         out  1       bank being written
//  wr_addr         out  ADDR_W  write address within bank
//  wr_pixel        out  PIX_W   write data
//  rd_bank         out  1       bank being displayed
//  rd_addr         out  ADDR_W  read address within bank
//  frame_ready     out  1       rd_bank holds a complete frame
//  frames_dropped  out  8       saturating drop count
//  field           out  1       current field (0 without INTERLACE_EN)
// BEHAVIOUR
//  Reset: wr_en=0, wr_addr=0, wr_pixel=0, wr_bank=0, rd_bank=1, rd_addr=0, frame_ready=0, frames_dropped=0, field=0.
//   Internally: pending=0, FSM=IDLE, col=0, row_base=0. Reset mid-frame abandons that frame.
//  Writer FSM: IDLE, FILL, GAP (INTERLACE_EN only), DONE.
//   IDLE->FILL on cam_sof; col=0, row_base=0.
//   FILL: each cam_valid produces, 1 cycle later, wr_en=1, wr_addr=row_base+col, wr_pixel=cam_pixel.
//    cam_valid low: no write, counters hold.
//   col wraps at WIDTH-1 and row_base += WIDTH (adder only, no multiplier).
//   Last pixel (row HEIGHT-1, col WIDTH-1): FILL->DONE, pending=1.
//   cam_sof while in FILL (short frame): restart at addr 0 in same bank; frames_dropped++.
//   DONE: cam_valid ignored (wr_en=0). Each cam_sof increments frames_dropped.
//  frames_dropped saturates at 255.
//  Swap: on disp_sof with registered pending=1:
//   rd_bank<=wr_bank, wr_bank<=~wr_bank, pending<=0, frame_ready<=1, FSM->IDLE.
//   disp_sof with pending=0: no swap; display repeats the same bank.
//   Simultaneous disp_sof and last-pixel write: no swap that cycle; swap at the next disp_sof.
//   Simultaneous disp_sof and cam_sof in DONE: swap wins; the cam_sof is counted dropped; FSM->IDLE.
//  Read path: rd_addr = disp_addr registered (1-cycle latency).
//   disp_addr >= WIDTH*HEIGHT clamps to WIDTH*HEIGHT-1.
//   rd_bank changes only on a disp_sof cycle.
//  Write latency: cam_valid to wr_en/wr_addr/wr_pixel is exactly 1 cycle.
// CONFIGURATION
//  INTERLACE_EN defined: camera delivers two fields per frame, each preceded by cam_sof.
//   Field 0 writes rows 0,2,..,HEIGHT-2; row_base steps by 2*WIDTH.
//   End of field 0 -> GAP, field=1. cam_sof in GAP -> FILL with row_base=WIDTH (rows 1,3,..,HEIGHT-1).
//   End of field 1 -> DONE, pending=1, field=0.
//   cam_sof during FILL restarts at field 0 and counts a drop.
//  INTERLACE_EN undefined: progressive only, GAP state absent, field tied 0.
// TESTING (WIDTH=4, HEIGHT=2 unless noted)
//  1 Assert reset 2 cycles -> all outputs at reset values; rd_bank=1, wr_bank=0.
//  2 cam_sof, 8 pixels 0x000001..0x000008 back-to-back -> wr_addr 0..7 in bank 0, data matches;
//    then disp_sof -> rd_bank=0, wr_bank=1, frame_ready=1.
//  3 cam_valid toggling 1,0,1,0 -> wr_addr advances only on valid cycles; wr_en never high during gaps.
//  4 Full frame then cam_sof twice before disp_sof -> frames_dropped=2, no wr_en;
//    disp_sof then swaps to bank 0.
//  5 cam_sof, 3 pixels, cam_sof, 8 pixels -> wr_addr restarts at 0, frames_dropped=1, frame completes.
//  6 INTERLACE_EN, HEIGHT=4 -> field 0 addrs 0-3,8-11; field 1 addrs 4-7,12-15; pending after field 1 only.

Source files
------------

// File: rtl/frame_bank_scheduler.sv
// frame_bank_scheduler
//   Ping-pong controller for a two-bank frame buffer sitting between camera capture and
//   display. Camera pixels are written in raster order into the write bank while the display
//   reads the other bank. Banks swap only on a display start-of-frame once a complete frame
//   is pending, so the displayed image never tears. Frames the display did not get to
//   consume are counted in a saturating drop counter.
//
// Optional feature macro: INTERLACE_EN
//   Defined: each frame arrives as two fields (even rows, then odd rows), each preceded by
//   cam_sof. Undefined (default): progressive frames only, field output tied low.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   cam_sof               pulse before the first pixel of a frame (or field)
//   cam_valid, cam_pixel  camera pixel stream, raster order
//   disp_sof              display start-of-frame (vsync) pulse
//   disp_addr             display read address within a frame
//   wr_en, wr_bank        buffer write strobe and target bank
//   wr_addr, wr_pixel     buffer write address within bank and data (1-cycle latency)
//   rd_bank, rd_addr      bank being displayed, registered and clamped read address
//   frame_ready           rd_bank holds a complete frame
//   frames_dropped        saturating count of frames dropped
//   field                 current field being captured
module frame_bank_scheduler #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned PIX_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_sof,
    input  logic              cam_valid,
    input  logic [PIX_W-1:0]  cam_pixel,
    input  logic              disp_sof,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_pixel,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              frame_ready,
    output logic [7:0]        frames_dropped,
    output logic              field
);

    localparam logic [ADDR_W-1:0] ColLast   = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] FrameLast = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LastBase  = ADDR_W'((HEIGHT - 1) * WIDTH);

`ifdef INTERLACE_EN
    localparam logic [ADDR_W-1:0] RowStep     = ADDR_W'(2 * WIDTH);
    localparam logic [ADDR_W-1:0] LastBaseF0  = ADDR_W'((HEIGHT - 2) * WIDTH);
    localparam logic [ADDR_W-1:0] OddRowStart = ADDR_W'(WIDTH);

    typedef enum logic [1:0] {StIdle, StFill, StGap, StDone} state_e;
`else
    localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(WIDTH);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              pending_q, pending_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_pixel_q, wr_pixel_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              frame_ready_q, frame_ready_d;
    logic [7:0]        dropped_q, dropped_d;
    logic              field_q, field_d;
    logic              drop_inc;
    logic              last_col;

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_base_d    = row_base_q;
        pending_d     = pending_q;
        wr_en_d       = 1'b0;
        wr_bank_d     = wr_bank_q;
        wr_addr_d     = wr_addr_q;
        wr_pixel_d    = wr_pixel_q;
        rd_bank_d     = rd_bank_q;
        frame_ready_d = frame_ready_q;
        dropped_d     = dropped_q;
        field_d       = field_q;
        drop_inc      = 1'b0;
        last_col      = (col_q == ColLast);
        rd_addr_d     = (disp_addr > FrameLast) ? FrameLast : disp_addr;

        unique case (state_q)
            StIdle: begin
                if (cam_sof) begin
                    state_d    = StFill;
                    col_d      = '0;
                    row_base_d = '0;
                end
            end
            StFill: begin
                if (cam_sof) begin
                    // Short frame: restart from the top of the same bank
                    col_d      = '0;
                    row_base_d = '0;
                    field_d    = 1'b0;
                    drop_inc   = 1'b1;
                end else if (cam_valid) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = row_base_q + col_q;
                    wr_pixel_d = cam_pixel;
                    if (last_col) begin
                        col_d      = '0;
                        row_base_d = row_base_q + RowStep;
`ifdef INTERLACE_EN
                        if (!field_q && row_base_q == LastBaseF0) begin
                            state_d = StGap;
                            field_d = 1'b1;
                        end else if (field_q && row_base_q == LastBase) begin
                            state_d   = StDone;
                            pending_d = 1'b1;
                            field_d   = 1'b0;
                        end
`else
                        if (row_base_q == LastBase) begin
                            state_d   = StDone;
                            pending_d = 1'b1;
                        end
`endif
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
`ifdef INTERLACE_EN
            StGap: begin
                if (cam_sof) begin
                    state_d    = StFill;
                    col_d      = '0;
                    row_base_d = OddRowStart;
                end
            end
`endif
            StDone: begin
                // Display has not taken the finished frame yet; incoming frames are lost
                if (cam_sof) begin
                    drop_inc = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (drop_inc && dropped_q != 8'hFF) begin
            dropped_d = dropped_q + 8'd1;
        end

        // pending_q is registered, so a frame finishing on this very cycle waits a vsync
        if (disp_sof && pending_q) begin
            rd_bank_d     = wr_bank_q;
            wr_bank_d     = ~wr_bank_q;
            pending_d     = 1'b0;
            frame_ready_d = 1'b1;
            state_d       = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            col_q         <= '0;
            row_base_q    <= '0;
            pending_q     <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_bank_q     <= 1'b0;
            wr_addr_q     <= '0;
            wr_pixel_q    <= '0;
            rd_bank_q     <= 1'b1;
            rd_addr_q     <= '0;
            frame_ready_q <= 1'b0;
            dropped_q     <= '0;
            field_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_base_q    <= row_base_d;
            pending_q     <= pending_d;
            wr_en_q       <= wr_en_d;
            wr_bank_q     <= wr_bank_d;
            wr_addr_q     <= wr_addr_d;
            wr_pixel_q    <= wr_pixel_d;
            rd_bank_q     <= rd_bank_d;
            rd_addr_q     <= rd_addr_d;
            frame_ready_q <= frame_ready_d;
            dropped_q     <= dropped_d;
            field_q       <= field_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_bank        = wr_bank_q;
    assign wr_addr        = wr_addr_q;
    assign wr_pixel       = wr_pixel_q;
    assign rd_bank        = rd_bank_q;
    assign rd_addr        = rd_addr_q;
    assign frame_ready    = frame_ready_q;
    assign frames_dropped = dropped_q;
    assign field          = field_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
module tb_frame_bank_scheduler;

    localparam int W = 4;
`ifdef INTERLACE_EN
    localparam int H = 4;
`else
    localparam int H = 2;
`endif
    localparam int N = W * H;

    typedef struct packed {
        logic        bank;
        logic [16:0] addr;
        logic [23:0] pix;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cam_sof = 1'b0;
    logic        cam_valid = 1'b0;
    logic [23:0] cam_pixel = '0;
    logic        disp_sof = 1'b0;
    logic [16:0] disp_addr = '0;
    logic        wr_en, wr_bank, rd_bank, frame_ready, field;
    logic [16:0] wr_addr, rd_addr;
    logic [23:0] wr_pixel;
    logic [7:0]  frames_dropped;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];

    frame_bank_scheduler #(
        .WIDTH (W),
        .HEIGHT(H),
        .ADDR_W(17),
        .PIX_W (24)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cam_sof       (cam_sof),
        .cam_valid     (cam_valid),
        .cam_pixel     (cam_pixel),
        .disp_sof      (disp_sof),
        .disp_addr     (disp_addr),
        .wr_en         (wr_en),
        .wr_bank       (wr_bank),
        .wr_addr       (wr_addr),
        .wr_pixel      (wr_pixel),
        .rd_bank       (rd_bank),
        .rd_addr       (rd_addr),
        .frame_ready   (frame_ready),
        .frames_dropped(frames_dropped),
        .field         (field)
    );

    always #5 clk = ~clk;

    // Scoreboard: every observed write must match the oldest expected write
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got bank=%0d addr=%0d pix=%h, required no write",
                         wr_bank, wr_addr, wr_pixel);
            end else begin
                e = exp_q.pop_front();
                if ({wr_bank, wr_addr, wr_pixel} !== e) begin
                    errors++;
                    $display("FAIL write_data: got bank=%0d addr=%0d pix=%h, required bank=%0d addr=%0d pix=%h",
                             wr_bank, wr_addr, wr_pixel, e.bank, e.addr, e.pix);
                end
            end
        end
    end

    task automatic drive(input logic sof, input logic valid, input logic [23:0] pix,
                         input logic dsof, input logic [16:0] daddr);
        @(negedge clk);
        cam_sof   = sof;
        cam_valid = valid;
        cam_pixel = pix;
        disp_sof  = dsof;
        disp_addr = daddr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 24'h0, 1'b0, 17'h0);
    endtask

    task automatic push(input logic bank, input int addr, input logic [23:0] pix);
        wr_t e;
        e.bank = bank;
        e.addr = 17'(addr);
        e.pix  = pix;
        exp_q.push_back(e);
    endtask

    // Progressive frame of N pixels into the given bank
    task automatic send_frame(input logic bank, input logic [23:0] base);
        drive(1'b1, 1'b0, 24'h0, 1'b0, 17'h0);
        for (int i = 0; i < N; i++) begin
            drive(1'b0, 1'b1, base + 24'(i), 1'b0, 17'h0);
            push(bank, i, base + 24'(i));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({wr_en, wr_addr, wr_pixel, wr_bank, rd_bank, rd_addr, frame_ready, frames_dropped, field}
            !== {1'b0, 17'h0, 24'h0, 1'b0, 1'b1, 17'h0, 1'b0, 8'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got en=%0d wa=%0d wp=%h wb=%0d rb=%0d ra=%0d fr=%0d fd=%0d f=%0d, required en=0 wa=0 wp=0 wb=0 rb=1 ra=0 fr=0 fd=0 f=0",
                     wr_en, wr_addr, wr_pixel, wr_bank, rd_bank, rd_addr, frame_ready,
                     frames_dropped, field);
        end
    endtask

    task automatic test_fill();
        send_frame(1'b0, 24'h000001);
        idle();
        idle();
        checks++;
        if ({wr_bank, rd_bank, frame_ready} !== 3'b010) begin
            errors++;
            $display("FAIL fill_preswap: got wb=%0d rb=%0d fr=%0d, required wb=0 rb=1 fr=0",
                     wr_bank, rd_bank, frame_ready);
        end
        drive(1'b0, 1'b0, 24'h0, 1'b1, 17'h0);
        idle();
        checks++;
        if ({wr_bank, rd_bank, frame_ready} !== 3'b101) begin
            errors++;
            $display("FAIL fill_swap: got wb=%0d rb=%0d fr=%0d, required wb=1 rb=0 fr=1",
                     wr_bank, rd_bank, frame_ready);
        end
    endtask

    task automatic test_read();
        logic [16:0] addrs[4] = '{17'd5, 17'd7, 17'd8, 17'd1000};
        logic [16:0] exps[4]  = '{17'd5, 17'd7, 17'd7, 17'd7};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 24'h0, 1'b0, addrs[i]);
            idle();
            checks++;
            if (rd_addr !== exps[i] || rd_bank !== 1'b0) begin
                errors++;
                $display("FAIL read_addr[%0d]: got ra=%0d rb=%0d, required ra=%0d rb=0",
                         i, rd_addr, rd_bank, exps[i]);
            end
        end
    endtask

    task automatic test_gaps();
        drive(1'b1, 1'b0, 24'h0, 1'b0, 17'h0);
        for (int i = 0; i < 2 * N; i++) begin
            if (i % 2 == 0) begin
                drive(1'b0, 1'b1, 24'h100 + 24'(i), 1'b0, 17'h0);
                push(1'b1, i / 2, 24'h100 + 24'(i));
            end else begin
                drive(1'b0, 1'b0, 24'hDEAD00 + 24'(i), 1'b0, 17'h0);
            end
        end
        idle();
        idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL gaps_missing: got %0d writes outstanding, required 0", exp_q.size());
        end
        drive(1'b0, 1'b0, 24'h0, 1'b1, 17'h0);
        idle();
        checks++;
        if ({wr_bank, rd_bank} !== 2'b01) begin
            errors++;
            $display("FAIL gaps_swap: got wb=%0d rb=%0d, required wb=0 rb=1", wr_bank, rd_bank);
        end
    endtask

    task automatic test_drop();
        send_frame(1'b0, 24'h000200);
        idle();
        drive(1'b1, 1'b1, 24'hBAD001, 1'b0, 17'h0);
        idle();
        drive(1'b1, 1'b1, 24'hBAD002, 1'b0, 17'h0);
        idle();
        idle();
        checks++;
        if (frames_dropped !== 8'd2 || wr_bank !== 1'b0) begin
            errors++;
            $display("FAIL drop_count: got fd=%0d wb=%0d, required fd=2 wb=0",
                     frames_dropped, wr_bank);
        end
        drive(1'b0, 1'b0, 24'h0, 1'b1, 17'h0);
        idle();
        checks++;
        if ({wr_bank, rd_bank} !== 2'b10) begin
            errors++;
            $display("FAIL drop_swap: got wb=%0d rb=%0d, required wb=1 rb=0", wr_bank, rd_bank);
        end
    endtask

    task automatic test_short();
        drive(1'b1, 1'b0, 24'h0, 1'b0, 17'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 24'h300 + 24'(i), 1'b0, 17'h0);
            push(1'b1, i, 24'h300 + 24'(i));
        end
        send_frame(1'b1, 24'h000310);
        idle();
        idle();
        checks++;
        if (frames_dropped !== 8'd3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL short_frame: got fd=%0d outstanding=%0d, required fd=3 outstanding=0",
                     frames_dropped, exp_q.size());
        end
        drive(1'b0, 1'b0, 24'h0, 1'b1, 17'h0);
        idle();
        checks++;
        if ({wr_bank, rd_bank} !== 2'b01) begin
            errors++;
            $display("FAIL short_swap: got wb=%0d rb=%0d, required wb=0 rb=1", wr_bank, rd_bank);
        end
    endtask

    task automatic test_simultaneous();
        // disp_sof on the last pixel: no swap that cycle
        drive(1'b1, 1'b0, 24'h0, 1'b0, 17'h0);
        for (int i = 0; i < N; i++) begin
            drive(1'b0, 1'b1, 24'h400 + 24'(i), (i == N - 1), 17'h0);
            push(1'b0, i, 24'h400 + 24'(i));
        end
        idle();
        checks++;
        if ({wr_bank, rd_bank} !== 2'b01) begin
            errors++;
            $display("FAIL late_swap_hold: got wb=%0d rb=%0d, required wb=0 rb=1",
                     wr_bank, rd_bank);
        end
        drive(1'b0, 1'b0, 24'h0, 1'b1, 17'h0);
        idle();
        checks++;
        if ({wr_bank, rd_bank} !== 2'b10) begin
            errors++;
            $display("FAIL late_swap: got wb=%0d rb=%0d, required wb=1 rb=0", wr_bank, rd_bank);
        end
        // disp_sof with cam_sof in DONE: swap wins, cam_sof counted dropped
        send_frame(1'b1, 24'h000500);
        idle();
        drive(1'b1, 1'b0, 24'h0, 1'b1, 17'h0);
        idle();
        checks++;
        if ({wr_bank, rd_bank} !== 2'b01 || frames_dropped !== 8'd4) begin
            errors++;
            $display("FAIL sof_collision: got wb=%0d rb=%0d fd=%0d, required wb=0 rb=1 fd=4",
                     wr_bank, rd_bank, frames_dropped);
        end
        // FSM back in IDLE: a new frame starts writing bank 0
        drive(1'b1, 1'b0, 24'h0, 1'b0, 17'h0);
        drive(1'b0, 1'b1, 24'h600, 1'b0, 17'h0);
        push(1'b0, 0, 24'h600);
        idle();
        idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_after_swap: got %0d writes outstanding, required 0",
                     exp_q.size());
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 1'b0, 24'h0, 1'b0, 17'h0);
        end
        idle();
        checks++;
        if (frames_dropped !== 8'd255) begin
            errors++;
            $display("FAIL drop_saturate: got fd=%0d, required fd=255", frames_dropped);
        end
    endtask

`ifdef INTERLACE_EN
    task automatic test_interlace();
        for (int f = 0; f < 2; f++) begin
            drive(1'b1, 1'b0, 24'h0, 1'b0, 17'h0);
            for (int i = 0; i < N / 2; i++) begin
                drive(1'b0, 1'b1, 24'h700 + 24'(16 * f + i), 1'b0, 17'h0);
                push(1'b0, f * W + (i / W) * 2 * W + (i % W), 24'h700 + 24'(16 * f + i));
            end
            idle();
            checks++;
            if (field !== 1'(1 - f)) begin
                errors++;
                $display("FAIL field_after_%0d: got field=%0d, required %0d", f, field, 1 - f);
            end
            drive(1'b0, 1'b0, 24'h0, 1'b1, 17'h0);
            idle();
            checks++;
            if (rd_bank !== 1'(1 - f)) begin
                errors++;
                $display("FAIL interlace_swap_%0d: got rb=%0d, required %0d", f, rd_bank, 1 - f);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL interlace_missing: got %0d outstanding, required 0", exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef INTERLACE_EN
        test_interlace();
`else
        test_fill();
        test_read();
        test_gaps();
        test_drop();
        test_short();
        test_simultaneous();
        test_saturate();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
